dmem_responder: RTL

Data-memory responder serving the pipelined MIPS core's memory-stage load/store requests. It latches one request at a time, inserts a configurable number of wait states, and holds the pipeline with `stallM` until the access completes. It returns full 32-bit words on reads and commits word or byte writes into an internal word array. It sits between the memory-stage outputs (`aluoutM`, `writedataM`) and the `readdataM` input of the datapath.

---
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS memory stage.
// Accepts one load/store at a time, inserts WAIT_STATES wait cycles and then
// performs the access. stallM holds the pipeline until the access completes.
// ackM pulses for one cycle when the access is complete.
module dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreqM,
  input  logic        memwriteM,
  input  logic        byteM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        ackM
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              byte_q, byte_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem_q [DEPTH];

  // Access controls for the current edge: the latched request, or the live
  // inputs when zero wait states complete the access on the accept edge.
  logic              acc_en;
  logic              acc_wr;
  logic              acc_byte;
  logic [IdxW-1:0]   acc_idx;
  logic [1:0]        acc_lane;
  logic [31:0]       acc_data;
  logic [31:0]       cur_word;
  logic [31:0]       merged;
  logic              mem_we;

  // Address bits above the array index are ignored, so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^addrM[31:IdxW+2];

  // Next-state, request latching and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    byte_d   = byte_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    wdata_d  = wdata_q;
    acc_en   = 1'b0;
    acc_wr   = wr_q;
    acc_byte = byte_q;
    acc_idx  = idx_q;
    acc_lane = lane_q;
    acc_data = wdata_q;
    stallM   = 1'b0;
    ackM     = 1'b0;
    unique case (state_q)
      StIdle: begin
        stallM = memreqM;
        if (memreqM) begin
          wr_d    = memwriteM;
          byte_d  = byteM;
          idx_d   = addrM[IdxW+1:2];
          lane_d  = addrM[1:0];
          wdata_d = writedataM;
          if (WAIT_STATES == 0) begin
            acc_en   = 1'b1;
            acc_wr   = memwriteM;
            acc_byte = byteM;
            acc_idx  = addrM[IdxW+1:2];
            acc_lane = addrM[1:0];
            acc_data = writedataM;
            state_d  = StDone;
          end else begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        stallM = 1'b1;
        if (cnt_q == 4'd0) begin
          acc_en  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        // A request still high here is the one just completed.
        ackM    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!reset) begin
      stallM = 1'b0;
    end
  end

  // Word merge for byte stores and next read-data value.
  always_comb begin
    cur_word = mem_q[acc_idx];
    merged   = acc_data;
    if (acc_byte) begin
      merged = cur_word;
      merged[{acc_lane, 3'b000} +: 8] = acc_data[7:0];
    end
    mem_we  = acc_en & acc_wr & reset;
    rdata_d = rdata_q;
    if (acc_en) begin
      rdata_d = acc_wr ? merged : cur_word;
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array; deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[acc_idx] <= merged;
    end
  end

  assign readdataM = rdata_q;

endmodule
